// File: rtl/regfile_dbg_ctrl_if.sv
// Debug host command/response channel for the register-file debug controller.
// The host drives the master side; the controller implements the slave side.
interface regfile_dbg_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 5
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_data;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [AW-1:0]    rsp_addr;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_last;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );
endinterface

// File: rtl/regfile_dbg_ctrl.sv
// Debug-side register file controller: halts the core, then performs a read,
// write, full dump or clear-all through the regfile debug port.
module regfile_dbg_ctrl #(
  parameter int WIDTH    = 64,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  regfile_dbg_ctrl_if.slave dbg,
  output logic             halt_req,
  input  logic             halted,
  output logic [AW-1:0]    ra_db,
  input  logic [WIDTH-1:0] rd_db,
  output logic [AW-1:0]    wa_db,
  output logic [WIDTH-1:0] wd_db,
  output logic             we_db
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_READ,
    S_WRITE,
    S_DUMP_RD,
    S_DUMP_RSP,
    S_CLEAR,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [AW-1:0]    rsp_addr_q, rsp_addr_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_last_q, rsp_last_d;

  logic             cmd_ready;
  logic             rsp_valid;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_last_d = rsp_last_q;

    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    halt_req   = 1'b1;
    ra_db      = '0;
    wa_db      = '0;
    wd_db      = '0;
    we_db      = 1'b0;

    case (state_q)
      S_IDLE: begin
        halt_req  = 1'b0;
        // Gated by reset so the host never sees ready during reset.
        cmd_ready = !reset;
        if (dbg.cmd_valid && cmd_ready) begin
          op_d    = op_e'(dbg.cmd_op);
          addr_d  = dbg.cmd_addr;
          data_d  = dbg.cmd_data;
          tmo_d   = '0;
          state_d = S_HALT_WAIT;
        end
      end

      S_HALT_WAIT: begin
        if (halted) begin
          idx_d = '0;
          case (op_q)
            OP_READ:  state_d = S_READ;
            OP_WRITE: state_d = S_WRITE;
            OP_DUMP:  state_d = S_DUMP_RD;
            OP_CLEAR: state_d = S_CLEAR;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          rsp_addr_d = addr_q;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_last_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_READ: begin
        ra_db      = addr_q;
        rsp_addr_d = addr_q;
        rsp_data_d = rd_db;
        rsp_err_d  = 1'b0;
        rsp_last_d = 1'b1;
        state_d    = S_RESP;
      end

      S_WRITE: begin
        wa_db      = addr_q;
        wd_db      = data_q;
        we_db      = (addr_q != ZERO_IDX);
        rsp_addr_d = addr_q;
        rsp_data_d = data_q;
        rsp_err_d  = (addr_q == ZERO_IDX);
        rsp_last_d = 1'b1;
        state_d    = S_RESP;
      end

      S_DUMP_RD: begin
        ra_db      = idx_q;
        rsp_addr_d = idx_q;
        rsp_data_d = rd_db;
        rsp_err_d  = 1'b0;
        rsp_last_d = (idx_q == LAST_IDX);
        state_d    = S_DUMP_RSP;
      end

      S_DUMP_RSP: begin
        rsp_valid = 1'b1;
        if (dbg.rsp_ready) begin
          if (rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_DUMP_RD;
          end
        end
      end

      S_CLEAR: begin
        wa_db = idx_q;
        wd_db = '0;
        we_db = (idx_q != ZERO_IDX);
        if (idx_q == LAST_IDX) begin
          rsp_addr_d = idx_q;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          rsp_last_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (dbg.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_last_q <= rsp_last_d;
    end
  end

  assign dbg.cmd_ready = cmd_ready;
  assign dbg.rsp_valid = rsp_valid;
  assign dbg.rsp_addr  = rsp_addr_q;
  assign dbg.rsp_data  = rsp_data_q;
  assign dbg.rsp_err   = rsp_err_q;
  assign dbg.rsp_last  = rsp_last_q;

endmodule

// File: doc/regfile_dbg_ctrl.md
Name: regfile_dbg_ctrl

Overview:
Debug-side controller for the register file's debug port (ra_db/rd_db, wa_db/wd_db/we_db). Accepts single-register read, single-register write, full dump and clear-all commands from the debug host over a valid/ready interface. Halts the core through a halt handshake before touching the register file, sequences the access, and returns results on a valid/ready response channel.

Parameters:
WIDTH, 64, register data width
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)
ZERO_REG, 31, hardwired-zero register index; the controller never writes it
TIMEOUT, 255, maximum HALT_WAIT cycles before aborting with error

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 read, 01 write, 10 dump, 11 clear-all
cmd_addr  in  AW  target register (read/write only)
cmd_data  in  WIDTH  write data (write only)
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_addr  out  AW  register index of response
rsp_data  out  WIDTH  read data / written data / zero
rsp_last  out  1  final response of a command
rsp_err  out  1  command aborted or illegal
halt_req  out  1  request core halt
halted  in  1  core is halted
ra_db  out  AW  regfile debug read address
rd_db  in  WIDTH  regfile debug read data (combinational from ra_db)
wa_db  out  AW  regfile debug write address
wd_db  out  WIDTH  regfile debug write data
we_db  out  1  regfile debug write enable

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset (including mid-command): state IDLE; all outputs 0 after the reset edge (cmd_ready 0 while reset is high, 1 in the first cycle after deassertion). Any in-flight command is dropped with no response. No we_db pulse occurs in the cycle after the reset edge.
- States: IDLE, HALT_WAIT, READ, WRITE, DUMP_RD, DUMP_RSP, CLEAR, RESP.
- IDLE: cmd_ready=1. When cmd_valid and cmd_ready are both high, latch op/addr/data, clear the timeout counter and go to HALT_WAIT. cmd_ready is 0 in every other state.
- HALT_WAIT: halt_req=1, and halt_req stays 1 through all later states until the RESP handshake completes.
  - halted=1: go to READ, WRITE, DUMP_RD (index=0) or CLEAR (index=0) according to op.
  - Counter reaches TIMEOUT with halted=0: go to RESP with rsp_err=1, rsp_data=0, rsp_last=1. No regfile access occurs.
- READ: ra_db=addr for one cycle; capture rd_db into rsp_data at the cycle end; go to RESP.
- WRITE: one cycle with wa_db=addr, wd_db=data, we_db=1; rsp_data=data; go to RESP.
  - addr==ZERO_REG: we_db stays 0 and rsp_err=1.
- DUMP_RD: ra_db=index; capture rd_db into rsp_data and index into rsp_addr; go to DUMP_RSP.
- DUMP_RSP: rsp_valid=1; rsp_last=1 iff index==NREG-1.
  - On rsp_ready: if last, drop halt_req and go to IDLE; else index+1 and go to DUMP_RD.
  - Rate: one response per 2 cycles at most.
- CLEAR: one register per cycle, index 0..NREG-1, wa_db=index, wd_db=0, we_db=1 except at index==ZERO_REG (we_db=0). After index NREG-1 go to RESP with rsp_err=0 and rsp_data=0. Total NREG cycles.
- RESP: rsp_valid=1; rsp_addr/rsp_data/rsp_err/rsp_last=1 held stable until rsp_ready. On the handshake: halt_req=0 and go to IDLE.
- Outputs rsp_* must not change while rsp_valid=1 and rsp_ready=0.
- The index counter is AW bits and never wraps: its terminal compare is NREG-1.
- we_db is high only in WRITE and CLEAR states, never more than one cycle per register.
- A halted deassertion after leaving HALT_WAIT is ignored; the core must stay halted while halt_req=1.
- Read latency with halted already 1: accept edge at cycle N, HALT_WAIT N+1, READ N+2, rsp_valid N+3.

Test Plan:
- Reset, then read x5 preloaded 0xDEAD_BEEF with halted=1 -> halt_req rises cycle N+1, ra_db=5 at N+2, rsp_valid at N+3 with rsp_data=0xDEADBEEF, rsp_last=1, rsp_err=0, halt_req low after the handshake.
- Write x1=all-ones, then read x1 -> exactly one we_db pulse with wa_db=1; read returns 0xFFFF_FFFF_FFFF_FFFF. Write x31=all-ones -> we_db never asserted, rsp_err=1; read x31 returns 0.
- Dump with rsp_ready toggling 1/0 every cycle -> 32 responses, rsp_addr 0..31 in order, data matches the preload, rsp_last only on addr 31, rsp_* stable while stalled.
- Clear-all after preload -> 32 CLEAR cycles, 31 we_db pulses with wd_db=0 (none at addr 31); subsequent dump returns all zeros.
- halted held 0 -> after 255 HALT_WAIT cycles, rsp_err=1 with no we_db or regfile access; cmd_ready returns the cycle after the handshake.
- Assert reset mid-dump at index 10 and mid-clear at index 3 -> no further responses or we_db; cmd_ready=1 the cycle after reset deasserts; a new read completes correctly.
